regwb_arbiter: RTL and testbench

Shares the integer register file's single write port (`we3`/`a3`/`wd3`) between the two writeback lanes of the STARBUG VLIW core. Each lane can present one result per cycle. The block writes at most one result per cycle, holds the rest in an in-order queue, and back-pressures the Writeback stage when the queue cannot absorb a worst-case cycle. It also reports queued-but-unwritten destinations so the hazard unit can stall dependent reads in Decode.

---
 rtl/regwb_arbiter.sv | 159 +++++++++++++++
 tb/tb_regwb_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/regwb_arbiter.sv
// Shares the register file's single write port between two writeback lanes using an in-order queue.
// Optional `define REGWB_BYPASS_EN: lets the oldest request write straight through when the queue is empty.
module regwb_arbiter #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            WeA,
    input  logic [4:0]      RdA,
    input  logic [XLEN-1:0] WdA,
    input  logic            WeB,
    input  logic [4:0]      RdB,
    input  logic [XLEN-1:0] WdB,
    output logic            we3,
    output logic [4:0]      a3,
    output logic [XLEN-1:0] wd3,
    output logic            StallWB,
    input  logic [4:0]      QRs1,
    input  logic [4:0]      QRs2,
    output logic            PendingHit1,
    output logic            PendingHit2
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] STALL_LVL = CW'(DEPTH - 1);

    logic [PW-1:0]   head_reg;
    logic [PW-1:0]   tail_reg;
    logic [PW-1:0]   tail_next1;
    logic [CW-1:0]   count_reg;

    logic [4:0]      entry_rd [DEPTH];
    logic [XLEN-1:0] entry_wd [DEPTH];
    logic [DEPTH-1:0] entry_valid;
    logic [DEPTH-1:0] match1;
    logic [DEPTH-1:0] match2;

    logic            stall;
    logic            eff_a;
    logic            eff_b;
    logic            pop;
    logic            q0_v;
    logic            q1_v;
    logic [1:0]      push_n;
    logic [4:0]      slot0_rd;
    logic [XLEN-1:0] slot0_wd;
    logic            port_we;
    logic [4:0]      port_rd;
    logic [XLEN-1:0] port_wd;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Stalling at DEPTH-1 leaves room for a two-push, one-pop cycle.
    assign stall = (count_reg >= STALL_LVL);
    assign eff_a = WeA && (RdA != 5'd0) && !stall;
    assign eff_b = WeB && (RdB != 5'd0) && !stall;
    assign tail_next1 = ptr_inc(tail_reg);

    always_comb begin
        port_we = 1'b0;
        port_rd = '0;
        port_wd = '0;
        pop     = 1'b0;
        q0_v    = eff_a;
        q1_v    = eff_b;
        if (count_reg != '0) begin
            pop     = 1'b1;
            port_we = 1'b1;
            port_rd = entry_rd[head_reg];
            port_wd = entry_wd[head_reg];
        end
`ifdef REGWB_BYPASS_EN
        else if (eff_a) begin
            port_we = 1'b1;
            port_rd = RdA;
            port_wd = WdA;
            q0_v    = 1'b0;
        end else if (eff_b) begin
            port_we = 1'b1;
            port_rd = RdB;
            port_wd = WdB;
            q1_v    = 1'b0;
        end
`endif
        // Compact the surviving requests so the older one lands at the tail first.
        slot0_rd = q0_v ? RdA : RdB;
        slot0_wd = q0_v ? WdA : WdB;
        push_n   = {1'b0, q0_v} + {1'b0, q1_v};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (pop) begin
                head_reg <= ptr_inc(head_reg);
            end
            if (push_n == 2'd1) begin
                tail_reg <= tail_next1;
            end else if (push_n == 2'd2) begin
                tail_reg <= ptr_inc(tail_next1);
            end
            count_reg <= count_reg + CW'(push_n) - CW'(pop);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic            valid_reg;
            logic [4:0]      rd_reg;
            logic [XLEN-1:0] wd_reg;
            logic            wr0;
            logic            wr1;

            assign wr0 = (push_n != 2'd0) && (tail_reg == PW'(gi));
            assign wr1 = (push_n == 2'd2) && (tail_next1 == PW'(gi));

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    valid_reg <= 1'b0;
                    rd_reg    <= '0;
                    wd_reg    <= '0;
                end else if (wr0) begin
                    valid_reg <= 1'b1;
                    rd_reg    <= slot0_rd;
                    wd_reg    <= slot0_wd;
                end else if (wr1) begin
                    valid_reg <= 1'b1;
                    rd_reg    <= RdB;
                    wd_reg    <= WdB;
                end else if (pop && (head_reg == PW'(gi))) begin
                    valid_reg <= 1'b0;
                end
            end

            assign entry_rd[gi]    = rd_reg;
            assign entry_wd[gi]    = wd_reg;
            assign entry_valid[gi] = valid_reg;
            assign match1[gi]      = valid_reg && (rd_reg == QRs1);
            assign match2[gi]      = valid_reg && (rd_reg == QRs2);
        end
    endgenerate

    assign we3         = port_we;
    assign a3          = port_rd;
    assign wd3         = port_wd;
    assign StallWB     = stall;
    // Entries popped this cycle still report a hit; the write only lands at the edge.
    assign PendingHit1 = (QRs1 != 5'd0) && (|match1) && (|entry_valid);
    assign PendingHit2 = (QRs2 != 5'd0) && (|match2) && (|entry_valid);

endmodule

// File: tb/tb_regwb_arbiter.sv
// Self-checking bench for regwb_arbiter: directed steps plus random traffic against a queue-level model.
// Follows REGWB_BYPASS_EN the same way the design does.
module tb_regwb_arbiter;
    localparam int XLEN  = 64;
    localparam int DEPTH = 4;
`ifdef REGWB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] wd;
    } ent_t;

    logic            clk;
    logic            rst;
    logic            WeA;
    logic [4:0]      RdA;
    logic [XLEN-1:0] WdA;
    logic            WeB;
    logic [4:0]      RdB;
    logic [XLEN-1:0] WdB;
    logic            we3;
    logic [4:0]      a3;
    logic [XLEN-1:0] wd3;
    logic            StallWB;
    logic [4:0]      QRs1;
    logic [4:0]      QRs2;
    logic            PendingHit1;
    logic            PendingHit2;

    int checks;
    int failures;
    int stall_seen;
    int cyc;

    ent_t        mq[$];
    logic [63:0] mrf [32];
    logic [63:0] drf [32];
    bit          dw  [32];
    logic [4:0]  wlog[$];

    regwb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(rst),
        .WeA(WeA), .RdA(RdA), .WdA(WdA),
        .WeB(WeB), .RdB(RdB), .WdB(WdB),
        .we3(we3), .a3(a3), .wd3(wd3),
        .StallWB(StallWB),
        .QRs1(QRs1), .QRs2(QRs2),
        .PendingHit1(PendingHit1), .PendingHit2(PendingHit2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; entered and left at posedge+1.
    task automatic cycle(input logic wea, input logic [4:0] rda, input logic [63:0] wda,
                         input logic web, input logic [4:0] rdb, input logic [63:0] wdb,
                         input logic [4:0] qa, input logic [4:0] qb, output bit stalled);
        bit          es, h1, h2, ea, eb, ewe;
        logic [4:0]  ea3;
        logic [63:0] ewd;
        WeA = wea; RdA = rda; WdA = wda;
        WeB = web; RdB = rdb; WdB = wdb;
        QRs1 = qa; QRs2 = qb;
        @(negedge clk);
        es = (mq.size() >= DEPTH - 1);
        h1 = 1'b0;
        h2 = 1'b0;
        foreach (mq[i]) begin
            if (qa != 5'd0 && mq[i].rd == qa) h1 = 1'b1;
            if (qb != 5'd0 && mq[i].rd == qb) h2 = 1'b1;
        end
        ea = wea && (rda != 5'd0) && !es;
        eb = web && (rdb != 5'd0) && !es;
        ewe = 1'b0; ea3 = 5'd0; ewd = 64'd0;
        if (mq.size() > 0) begin
            ewe = 1'b1; ea3 = mq[0].rd; ewd = mq[0].wd;
            void'(mq.pop_front());
        end else if (BYP && ea) begin
            ewe = 1'b1; ea3 = rda; ewd = wda; ea = 1'b0;
        end else if (BYP && eb) begin
            ewe = 1'b1; ea3 = rdb; ewd = wdb; eb = 1'b0;
        end
        if (ea) mq.push_back(ent_t'{rd: rda, wd: wda});
        if (eb) mq.push_back(ent_t'{rd: rdb, wd: wdb});
        chk("stall", StallWB, es);
        chk("we3", we3, ewe);
        chk("a3", a3, ea3);
        chk("wd3", wd3, ewd);
        chk("hit1", PendingHit1, h1);
        chk("hit2", PendingHit2, h2);
        if (es) stall_seen++;
        if (ewe) mrf[ea3] = ewd;
        if (we3 === 1'b1) begin
            drf[a3] = wd3;
            dw[a3]  = 1'b1;
            wlog.push_back(a3);
        end
        $display("cyc %0d A=%0d/x%0d B=%0d/x%0d stall=%0d we3=%0d a3=%0d wd3=%0h q=%0d",
                 cyc, wea, rda, web, rdb, StallWB, we3, a3, wd3, mq.size());
        cyc++;
        stalled = es;
        @(posedge clk);
        #1;
    endtask

    // Upstream holds the request pair while stalled, with a bounded retry budget.
    task automatic issue(input logic wea, input logic [4:0] rda, input logic [63:0] wda,
                         input logic web, input logic [4:0] rdb, input logic [63:0] wdb,
                         input logic [4:0] qa, input logic [4:0] qb);
        bit st;
        int n;
        n = 0;
        do begin
            cycle(wea, rda, wda, web, rdb, wdb, qa, qb, st);
            n++;
        end while (st && n < 32);
        chk("stall_bound", st, 1'b0);
    endtask

    task automatic idle(input int n, input logic [4:0] qa, input logic [4:0] qb);
        bit st;
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, qa, qb, st);
    endtask

    initial begin
        logic [4:0]  disc[$];
        logic [4:0]  ra, rb, qa, qb;
        logic [63:0] va, vb;
        bit          st;
        int          n;
        checks = 0; failures = 0; stall_seen = 0; cyc = 0;
        for (int i = 0; i < 32; i++) begin
            mrf[i] = 64'd0; drf[i] = 64'd0; dw[i] = 1'b0;
        end
        rst = 1'b1;
        WeA = 1'b0; RdA = 5'd0; WdA = '0;
        WeB = 1'b0; RdB = 5'd0; WdB = '0;
        QRs1 = 5'd5; QRs2 = 5'd9;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we3", we3, 1'b0);
        chk("rst_a3", a3, 5'd0);
        chk("rst_wd3", wd3, 64'd0);
        chk("rst_stall", StallWB, 1'b0);
        chk("rst_hit1", PendingHit1, 1'b0);
        chk("rst_hit2", PendingHit2, 1'b0);
        rst = 1'b0;

        // Single lane-A write to x5; QRs1=5 watches the pending window.
        issue(1'b1, 5'd5, 64'h11, 1'b0, 5'd0, 64'd0, 5'd5, 5'd0);
        idle(2, 5'd5, 5'd0);
        chk("x5_value", drf[5], 64'h11);

        // Same destination on both lanes: B is younger and must win.
        issue(1'b1, 5'd3, 64'hA, 1'b1, 5'd3, 64'hB, 5'd3, 5'd0);
        idle(2, 5'd3, 5'd0);
        chk("x3_final", drf[3], 64'hB);

        // x0 request dropped, x7 written.
        issue(1'b1, 5'd0, 64'hDEAD, 1'b1, 5'd7, 64'h7, 5'd0, 5'd7);
        idle(2, 5'd0, 5'd7);
        chk("x7_value", drf[7], 64'h7);
        chk("x0_never", dw[0], 1'b0);

        // Dual requests every cycle from empty: must stall, then drain 1..8 in order.
        wlog.delete();
        stall_seen = 0;
        for (int p = 0; p < 4; p++)
            issue(1'b1, 5'(2 * p + 1), 64'(100 + 2 * p + 1), 1'b1, 5'(2 * p + 2), 64'(100 + 2 * p + 2), 5'd0, 5'd0);
        idle(6, 5'd0, 5'd0);
        chk("burst_stalled", (stall_seen != 0), 1'b1);
        chk("burst_count", wlog.size(), 8);
        for (int i = 0; i < 8 && i < wlog.size(); i++) chk("burst_order", wlog[i], 5'(i + 1));

        // QRs1=0 never hits even with x9 queued.
        issue(1'b1, 5'd12, 64'hC, 1'b1, 5'd9, 64'h9, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd9, st);
        idle(3, 5'd0, 5'd0);

        // Fill two entries, then reset asynchronously mid-cycle.
        n = 0;
        while (mq.size() < 2 && n < 8) begin
            issue(1'b1, 5'(20 + 2 * n), 64'h20, 1'b1, 5'(21 + 2 * n), 64'h21, 5'd0, 5'd0);
            n++;
        end
        chk("fill_two", mq.size(), 2);
        foreach (mq[i]) disc.push_back(mq[i].rd);
        WeA = 1'b0; WeB = 1'b0;
        QRs1 = mq[0].rd; QRs2 = mq[1].rd;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_we3", we3, 1'b0);
        chk("arst_stall", StallWB, 1'b0);
        chk("arst_hit1", PendingHit1, 1'b0);
        chk("arst_hit2", PendingHit2, 1'b0);
        mq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4, disc[0], disc[1]);
        foreach (disc[i]) chk("discard_unwritten", dw[disc[i]], 1'b0);

        // Random traffic against the queue model.
        for (int t = 0; t < 250; t++) begin
            ra = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rb = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            va = {$urandom, $urandom};
            vb = {$urandom, $urandom};
            qa = 5'($urandom_range(0, 31));
            qb = (mq.size() > 0 && $urandom_range(0, 1) == 1) ? mq[$urandom_range(0, mq.size() - 1)].rd
                                                               : 5'($urandom_range(0, 31));
            issue($urandom_range(0, 3) != 0, ra, va, $urandom_range(0, 2) != 0, rb, vb, qa, qb);
        end
        idle(8, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) chk("regfile", drf[i], mrf[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
